// File: rtl/vecmat_feed_ctrl_pkg.sv
// Shared constants and types for the vector/matrix feed controller of the
// 64-lane dot-product engine.
package vecmat_feed_ctrl_pkg;

  localparam int unsigned DW           = 16;
  localparam int unsigned VEC_DEPTH    = 64;
  localparam int unsigned NUM_ROWS     = 64;
  localparam int unsigned BUS_W        = DW * VEC_DEPTH;
  localparam int unsigned IDX_W        = $clog2((NUM_ROWS > VEC_DEPTH) ? NUM_ROWS : VEC_DEPTH);
  // Engine depth: multiplier register + adder-tree flop + output register.
  localparam int unsigned PIPE_LAT_DEF = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_Q,
    LOAD_K,
    ISSUE,
    DRAIN
  } state_e;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } token_t;

endpackage

// File: rtl/vecmat_feed_ctrl_if.sv
// Element stream, engine buses and score return of the feed controller.
interface vecmat_feed_ctrl_if;
  import vecmat_feed_ctrl_pkg::*;

  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [BUS_W-1:0] vector;
  logic [BUS_W-1:0] matrix;
  logic [DW-1:0]    dot_in;
  logic             score_valid;
  logic [DW-1:0]    score_data;
  logic [IDX_W-1:0] score_idx;
  logic             busy;
  logic             done;

  modport master (
    output start, in_valid, in_data, dot_in,
    input  in_ready, vector, matrix, score_valid, score_data, score_idx, busy, done
  );

  modport slave (
    input  start, in_valid, in_data, dot_in,
    output in_ready, vector, matrix, score_valid, score_data, score_idx, busy, done
  );

endinterface

// File: rtl/vecmat_feed_ctrl_lat_track.sv
// Token shift register mirroring the engine latency, plus the score capture
// register fed when a token leaves the pipe.
module vecmat_lat_track
  import vecmat_feed_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_in,
  input  logic [IDX_W-1:0] idx_in,
  input  logic [DW-1:0]    dot_in,
  output logic             score_valid,
  output logic [DW-1:0]    score_data,
  output logic [IDX_W-1:0] score_idx,
  output logic             score_last,
  output logic             pipe_busy_c
);

  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(NUM_ROWS - 1);

  token_t [PIPE_LAT-1:0] pipe_q;
  logic                  score_valid_q;
  logic [DW-1:0]         score_data_q;
  logic [IDX_W-1:0]      score_idx_q;
  logic                  score_last_q;
  token_t                exit_c;

  assign exit_c = pipe_q[PIPE_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q        <= '0;
      score_valid_q <= 1'b0;
      score_data_q  <= '0;
      score_idx_q   <= '0;
      score_last_q  <= 1'b0;
    end else begin
      pipe_q[0].vld <= shift_in;
      pipe_q[0].idx <= idx_in;
      for (int i = 1; i < int'(PIPE_LAT); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      score_valid_q <= exit_c.vld;
      score_last_q  <= exit_c.vld && (exit_c.idx == LAST_ROW);
      if (exit_c.vld) begin
        score_data_q <= dot_in;
        score_idx_q  <= exit_c.idx;
      end
    end
  end

  // Any token still in flight keeps the controller in DRAIN.
  always_comb begin
    pipe_busy_c = 1'b0;
    for (int i = 0; i < int'(PIPE_LAT); i++) begin
      pipe_busy_c = pipe_busy_c | pipe_q[i].vld;
    end
  end

  assign score_valid = score_valid_q;
  assign score_data  = score_data_q;
  assign score_idx   = score_idx_q;
  assign score_last  = score_last_q;

endmodule

// File: rtl/vecmat_feed_ctrl.sv
// Packs a serial Q vector and NUM_ROWS K rows onto the engine buses, issues
// one row per dot product and returns each score tagged with its row index.
module vecmat_feed_ctrl
  import vecmat_feed_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
  input logic               clk,
  input logic               reset,
  vecmat_feed_ctrl_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_ELEM = IDX_W'(VEC_DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_ROW  = IDX_W'(NUM_ROWS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] elem_q, elem_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [BUS_W-1:0] vector_q, vector_d;
  logic [BUS_W-1:0] matrix_q, matrix_d;
  logic [BUS_W-1:0] staging_q, staging_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             accept_c;
  logic             issue_c;
  logic             pipe_busy_c;

  assign accept_c = bus.in_valid & in_ready_q;
  assign issue_c  = (state_q == ISSUE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      elem_q     <= '0;
      row_q      <= '0;
      vector_q   <= '0;
      matrix_q   <= '0;
      staging_q  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      elem_q     <= elem_d;
      row_q      <= row_d;
      vector_q   <= vector_d;
      matrix_q   <= matrix_d;
      staging_q  <= staging_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  // matrix only moves on the edge into ISSUE, so loading the next row never
  // disturbs stages already in flight in the engine.
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    row_d     = row_q;
    vector_d  = vector_q;
    matrix_d  = matrix_q;
    staging_d = staging_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD_Q;
          elem_d  = '0;
          row_d   = '0;
        end
      end
      LOAD_Q: begin
        if (accept_c) begin
          vector_d[int'(elem_q) * DW +: DW] = bus.in_data;
          if (elem_q == LAST_ELEM) begin
            elem_d  = '0;
            state_d = LOAD_K;
          end else begin
            elem_d = elem_q + IDX_W'(1);
          end
        end
      end
      LOAD_K: begin
        if (accept_c) begin
          staging_d[int'(elem_q) * DW +: DW] = bus.in_data;
          if (elem_q == LAST_ELEM) begin
            elem_d   = '0;
            matrix_d = staging_d;
            state_d  = ISSUE;
          end else begin
            elem_d = elem_q + IDX_W'(1);
          end
        end
      end
      ISSUE: begin
        if (row_q == LAST_ROW) begin
          row_d   = '0;
          state_d = DRAIN;
        end else begin
          row_d   = row_q + IDX_W'(1);
          state_d = LOAD_K;
        end
      end
      DRAIN: begin
        if (!pipe_busy_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == LOAD_Q) || (state_d == LOAD_K);
    busy_d     = (state_d != IDLE);
  end

  vecmat_lat_track #(
    .PIPE_LAT (PIPE_LAT)
  ) u_lat_track (
    .clk         (clk),
    .rst_n       (reset),
    .shift_in    (issue_c),
    .idx_in      (row_q),
    .dot_in      (bus.dot_in),
    .score_valid (bus.score_valid),
    .score_data  (bus.score_data),
    .score_idx   (bus.score_idx),
    .score_last  (bus.done),
    .pipe_busy_c (pipe_busy_c)
  );

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.vector   = vector_q;
  assign bus.matrix   = matrix_q;

endmodule

// File: tb/tb_vecmat_feed_ctrl.sv
// Bench for vecmat_feed_ctrl: two instances (PIPE_LAT 3 and 5) driven in
// lockstep, each behind a behavioural engine, scored against array data.
module tb_vecmat_feed_ctrl;
  import vecmat_feed_ctrl_pkg::*;

  localparam int unsigned LAT_A = 3;
  localparam int unsigned LAT_B = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;

  vecmat_feed_ctrl_if ifa ();
  vecmat_feed_ctrl_if ifb ();

  vecmat_feed_ctrl #(.PIPE_LAT(LAT_A)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  vecmat_feed_ctrl #(.PIPE_LAT(LAT_B)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  assign ifa.start = start;    assign ifb.start = start;
  assign ifa.in_valid = in_valid; assign ifb.in_valid = in_valid;
  assign ifa.in_data = in_data;  assign ifb.in_data = in_data;

  // Engine stand-in: Q8.8 dot product of the live buses, delayed PIPE_LAT cycles.
  function automatic logic [DW-1:0] engine_dot(input logic [BUS_W-1:0] v, input logic [BUS_W-1:0] m);
    longint acc = 0;
    for (int i = 0; i < int'(VEC_DEPTH); i++)
      acc += longint'($signed(v[i*DW +: DW])) * longint'($signed(m[i*DW +: DW]));
    return DW'(acc >>> 8);
  endfunction

  logic [DW-1:0] eng_a [LAT_A];
  logic [DW-1:0] eng_b [LAT_B];
  always @(posedge clk) begin
    eng_a[0] <= engine_dot(ifa.vector, ifa.matrix);
    eng_b[0] <= engine_dot(ifb.vector, ifb.matrix);
    for (int i = 1; i < int'(LAT_A); i++) eng_a[i] <= eng_a[i-1];
    for (int i = 1; i < int'(LAT_B); i++) eng_b[i] <= eng_b[i-1];
  end
  assign ifa.dot_in = eng_a[LAT_A-1];
  assign ifb.dot_in = eng_b[LAT_B-1];

  // Job data and the expected score for a row, from the arrays alone.
  logic [DW-1:0] q_arr [VEC_DEPTH];
  logic [DW-1:0] k_arr [NUM_ROWS][VEC_DEPTH];

  function automatic logic [DW-1:0] ref_score(input int r);
    longint acc = 0;
    for (int i = 0; i < int'(VEC_DEPTH); i++)
      acc += longint'($signed(q_arr[i])) * longint'($signed(k_arr[r][i]));
    return DW'(acc >>> 8);
  endfunction

  typedef struct { int cyc; int idx; logic [DW-1:0] data; } exp_t;
  typedef struct { int cyc; int row; } iss_t;
  exp_t exp_a [$];
  exp_t exp_b [$];
  iss_t iss_q [$];

  int n_chk = 0;
  int n_pass = 0;
  int n_scores [2];
  int n_done [2];
  bit busy_chk [2];
  logic [BUS_W-1:0] mat_prev;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
  endtask

  task automatic score_mon(input int ch, input string pfx, input logic sv, input logic [DW-1:0] sd,
                           input logic [IDX_W-1:0] si, input logic dn, input logic bz, input logic rdy);
    exp_t e;
    bit   have;
    have = (ch == 0) ? (exp_a.size() > 0) : (exp_b.size() > 0);
    if (have) e = (ch == 0) ? exp_a[0] : exp_b[0];
    if (busy_chk[ch]) begin
      chk({pfx, "busy_fall"}, bz, 1'b0);
      busy_chk[ch] = 1'b0;
    end
    if (sv) begin
      chk({pfx, "score_expected"}, have, 1'b1);
      if (have) begin
        if (ch == 0) void'(exp_a.pop_front()); else void'(exp_b.pop_front());
        chk({pfx, "score_cycle"}, cyc, e.cyc);
        chk({pfx, "score_idx"}, si, e.idx);
        chk({pfx, "score_data"}, sd, e.data);
        chk({pfx, "done_on_last"}, dn, e.idx == int'(NUM_ROWS - 1));
      end
      n_scores[ch]++;
      if (dn) begin
        n_done[ch]++;
        chk({pfx, "busy_at_done"}, bz, 1'b1);
        chk({pfx, "ready_in_drain"}, rdy, 1'b0);
        busy_chk[ch] = 1'b1;
      end
    end else begin
      if (have && cyc > e.cyc) begin
        chk({pfx, "score_missing"}, sv, 1'b1);
        if (ch == 0) void'(exp_a.pop_front()); else void'(exp_b.pop_front());
      end
      if (dn) chk({pfx, "done_without_score"}, dn, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!reset) begin
      mat_prev = ifa.matrix;
    end else begin
      if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
        for (int i = 0; i < int'(VEC_DEPTH); i++) begin
          chk("vector_elem", ifa.vector[i*DW +: DW], q_arr[i]);
          chk("matrix_elem", ifa.matrix[i*DW +: DW], k_arr[iss_q[0].row][i]);
        end
        chk("ready_in_issue", ifa.in_ready, 1'b0);
        void'(iss_q.pop_front());
      end else begin
        chk("matrix_hold", ifa.matrix === mat_prev, 1'b1);
      end
      mat_prev = ifa.matrix;
      score_mon(0, "L3_", ifa.score_valid, ifa.score_data, ifa.score_idx, ifa.done, ifa.busy, ifa.in_ready);
      score_mon(1, "L5_", ifb.score_valid, ifb.score_data, ifb.score_idx, ifb.done, ifb.busy, ifb.in_ready);
    end
  end

  task automatic chk_idle();
    chk("idle_state_a", dut_a.state_q, IDLE);
    chk("idle_state_b", dut_b.state_q, IDLE);
    chk("idle_ready", ifa.in_ready | ifb.in_ready, 1'b0);
    chk("idle_busy", ifa.busy | ifb.busy, 1'b0);
    chk("idle_done", ifa.done | ifb.done, 1'b0);
    chk("idle_score_valid", ifa.score_valid | ifb.score_valid, 1'b0);
    chk("idle_score_data", ifa.score_data | ifb.score_data, '0);
    chk("idle_score_idx", ifa.score_idx | ifb.score_idx, '0);
    chk("idle_vector_zero", (ifa.vector | ifb.vector) == '0, 1'b1);
    chk("idle_matrix_zero", (ifa.matrix | ifb.matrix) == '0, 1'b1);
  endtask

  task automatic send(input logic [DW-1:0] d, input int stall_pct, output int acc_cyc);
    int guard = 0;
    while ($urandom_range(99) < stall_pct) begin
      in_valid = 1'b0;
      in_data  = DW'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    while (!ifa.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("accept_timeout", ifa.in_ready, 1'b1);
    @(negedge clk);
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    while ((ifa.busy || ifb.busy) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk(tag, ifa.busy | ifb.busy, 1'b0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    start    = 1'b0;
    reset    = 1'b0;
    #1;
    chk_idle();
    exp_a.delete();
    exp_b.delete();
    iss_q.delete();
    busy_chk[0] = 1'b0;
    busy_chk[1] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("post_reset_score_valid", ifa.score_valid | ifb.score_valid, 1'b0);
      chk("post_reset_ready", ifa.in_ready | ifb.in_ready, 1'b0);
      chk("post_reset_busy", ifa.busy | ifb.busy, 1'b0);
    end
    chk_idle();
  endtask

  // kind: 0 unit data, 1 packing pattern, 2 random, 3 reuse previous data.
  task automatic run_job(input int kind, input int stall, input int start_row,
                         input int abort_row, input int abort_elem);
    int   acc;
    exp_t e;
    iss_t s;
    if (kind != 3) begin
      for (int i = 0; i < int'(VEC_DEPTH); i++)
        q_arr[i] = (kind == 0) ? 16'h0100 : (kind == 1) ? DW'(i) : DW'($urandom);
      for (int r = 0; r < int'(NUM_ROWS); r++)
        for (int i = 0; i < int'(VEC_DEPTH); i++)
          k_arr[r][i] = (kind == 0) ? DW'(r) : (kind == 1 && r == 0) ? (16'h8000 | DW'(i)) : DW'($urandom);
    end
    wait_idle("idle_before_start");
    n_scores[0] = 0; n_scores[1] = 0;
    n_done[0] = 0;   n_done[1] = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < int'(VEC_DEPTH); i++) send(q_arr[i], stall, acc);
    for (int r = 0; r < int'(NUM_ROWS); r++) begin
      for (int i = 0; i < int'(VEC_DEPTH); i++) begin
        if (r == abort_row && i == abort_elem) begin
          do_reset();
          return;
        end
        if (r == start_row && i == 5) start = 1'b1;
        send(k_arr[r][i], stall, acc);
        start = 1'b0;
      end
      s.cyc = acc; s.row = r;
      iss_q.push_back(s);
      e.idx = r; e.data = ref_score(r);
      e.cyc = acc + int'(LAT_A) + 1; exp_a.push_back(e);
      e.cyc = acc + int'(LAT_B) + 1; exp_b.push_back(e);
    end
    wait_idle("job_complete_timeout");
    @(negedge clk);
    chk("L3_score_count", n_scores[0], NUM_ROWS);
    chk("L5_score_count", n_scores[1], NUM_ROWS);
    chk("L3_done_count", n_done[0], 1);
    chk("L5_done_count", n_done[1], 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    chk_idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_job(0, 0, -1, -1, -1);
    run_job(1, 0, 10, -1, -1);
    run_job(2, 0, -1, -1, -1);
    run_job(3, 70, -1, -1, -1);
    run_job(2, 0, -1, 5, 30);
    run_job(0, 0, -1, -1, -1);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vecmat_feed_ctrl.md
Name: vecmat_feed_ctrl

Overview:
- Producer side of the 64-lane vector-matrix dot-product engine.
- Accepts a serial stream of 16-bit fixed-point elements: one Q vector, then NUM_ROWS K rows.
- Packs the elements into the 1024-bit vector/matrix buses and issues one row per dot product.
- Tracks the engine's fixed pipeline latency and returns each 16-bit score tagged with its row index.

Parameters:
- DW, 16, element width in bits
- VEC_DEPTH, 64, elements per vector/row (bus width = DW*VEC_DEPTH = 1024)
- NUM_ROWS, 64, K rows per job
- PIPE_LAT, 3, cycles from an issue edge to a valid dot_in on the engine output
- IDX_W, 6, width of the row and element counters (clog2 of max(NUM_ROWS, VEC_DEPTH))

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a job (sampled in IDLE only)
- in_valid  in  1  element valid
- in_ready  out  1  element accepted when in_valid && in_ready
- in_data  in  DW  element, signed fixed point
- vector  out  1024  packed Q vector to engine; element i at [i*DW +: DW]
- matrix  out  1024  packed K row to engine; element i at [i*DW +: DW]
- dot_in  in  DW  engine data_out
- score_valid  out  1  one-cycle pulse: score_data/score_idx valid
- score_data  out  DW  captured dot product
- score_idx  out  IDX_W  K row index of the score
- busy  out  1  high from start acceptance until the last score is emitted
- done  out  1  one-cycle pulse with the last score_valid

Behaviour:
- Reset (reset=0, asynchronous) clears all outputs and internal state to 0 and forces state IDLE. Includes vector, matrix, staging buffer, counters and token pipe.
- Reset asserted mid-job abandons the job. No score or done is produced for it.
- FSM states: IDLE, LOAD_Q, LOAD_K, ISSUE, DRAIN.
  - IDLE: in_ready=0. start=1 -> LOAD_Q with elem_cnt=0, row_cnt=0, busy=1.
  - LOAD_Q: in_ready=1. Each accepted element writes vector[elem_cnt*DW +: DW]. elem_cnt wraps to 0 at VEC_DEPTH-1 and the FSM moves to LOAD_K.
  - LOAD_K: in_ready=1. Each accepted element writes staging[elem_cnt*DW +: DW]. The accept of element VEC_DEPTH-1 moves to ISSUE.
  - ISSUE (exactly 1 cycle):
    - in_ready=0.
    - The matrix register loads staging, with the final element merged, on the edge that leaves LOAD_K. matrix is therefore complete throughout the ISSUE cycle.
    - A token {row_cnt} enters the PIPE_LAT-deep token shift register.
    - row_cnt increments.
    - If row_cnt was NUM_ROWS-1 -> DRAIN, else -> LOAD_K.
  - DRAIN: in_ready=0. Waits until the token pipe is empty, then -> IDLE, busy=0.
- Stability of the engine buses:
  - vector is held constant from the end of LOAD_Q until the next job's LOAD_Q.
  - matrix changes only on the ISSUE-entry edge.
  - Because of this, the next row's loading never disturbs in-flight engine stages.
- Score capture:
  - When a token exits the pipe (PIPE_LAT cycles after its ISSUE cycle), register score_data<=dot_in and score_idx<=token.
  - Pulse score_valid for 1 cycle.
  - Total latency from ISSUE cycle to score_valid high is PIPE_LAT+1 cycles.
- done pulses coincident with the score_valid whose score_idx = NUM_ROWS-1.
- There is no backpressure on scores; the consumer must accept every pulse.
- in_valid while in_ready=0 is ignored; no element is consumed.
- start while busy is ignored.
- Gaps in in_valid simply stall the counters.
- Minimum spacing between issues is VEC_DEPTH+1 cycles, which is greater than PIPE_LAT, so at most one token is ever in flight. Still, the pipe is implemented as a full shift register so that any PIPE_LAT up to VEC_DEPTH is safe.
- Arithmetic: none on data. Counters are IDX_W wide and wrap explicitly at their terminal values.

Decomposition:
- Shared package holds:
  - DW, VEC_DEPTH, bus width constant (DW*VEC_DEPTH)
  - state enum {IDLE, LOAD_Q, LOAD_K, ISSUE, DRAIN}
  - default PIPE_LAT matching the engine (multiplier register + tree flop stage + output register)
- One sub-module: vecmat_lat_track. It contains the PIPE_LAT-deep valid/index token shift register and the score capture register, with ports shift_in, idx_in, dot_in, score_valid, score_data, score_idx.

Test Plan:
- Reset/idle:
  - Stimulus: reset=0 pulsed mid-LOAD_K (row 5, element 30), then release with start=0.
  - Required: all outputs 0, state IDLE, in_ready=0, no score_valid for 100 cycles.
- Single job, unit data:
  - Stimulus: start; Q elements all 16'h0100; K row r elements all r; engine model = behavioral 64-lane dot product with PIPE_LAT delay.
  - Required: 64 score_valid pulses, score_idx 0..63 in order, score_data matching the model, done with idx 63, busy falls one cycle after done.
- Packing order:
  - Stimulus: Q element i = i, K row 0 element i = 16'h8000|i.
  - Required: vector[i*16+:16]=i and matrix[i*16+:16]=16'h8000|i during the ISSUE cycle; matrix unchanged until the next ISSUE.
- Stalls:
  - Stimulus: in_valid toggled at a random 30% duty.
  - Required: identical scores and order to the no-stall run; no element dropped or duplicated; in_ready=0 in ISSUE/DRAIN.
- Latency:
  - Stimulus: ISSUE at cycle T with PIPE_LAT=3.
  - Required: score_valid exactly at cycle T+4. Repeat with PIPE_LAT=5 -> T+6.
- Start while busy:
  - Stimulus: start pulsed during LOAD_K of row 10.
  - Required: ignored; the job completes with 64 scores and a single done.
